// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared fault codes and sensor state encoding for the irrigation plant
package irrigation_pkg;

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_MID_LOW   = 2'b01;
  localparam logic [1:0] FAULT_LOW_LOW   = 2'b10;
  localparam logic [1:0] FAULT_HIGH_HIGH = 2'b11;

  typedef enum logic {
    SENSOR_OFF = 1'b0,
    SENSOR_ON  = 1'b1
  } sensor_state_e;

endpackage

// File: rtl/water_tank_model_if.sv
// rtl/water_tank_model_if.sv - valve commands in, level sensors and plant status out
interface water_tank_model_if #(
  parameter int LEVEL_WIDTH = 8
);
  logic                   water_supply_valvule;
  logic                   splinker_bomb;
  logic                   dripper_valvule;
  logic [1:0]             fault_inject;
  logic                   clear_flags;
  logic                   low_water_level;
  logic                   mid_water_level;
  logic                   high_water_level;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   overflow;
  logic                   dry_run;

  modport master (
    output water_supply_valvule, splinker_bomb, dripper_valvule, fault_inject, clear_flags,
    input  low_water_level, mid_water_level, high_water_level, level, overflow, dry_run
  );

  modport slave (
    input  water_supply_valvule, splinker_bomb, dripper_valvule, fault_inject, clear_flags,
    output low_water_level, mid_water_level, high_water_level, level, overflow, dry_run
  );
endinterface

// File: rtl/level_sensor.sv
// rtl/level_sensor.sv - hysteretic level switch: sets at THRESH, clears below THRESH-HYST
module level_sensor
  import irrigation_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int THRESH     = 32,
  parameter int HYST       = 4,
  parameter int INIT_LEVEL = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] level,
  output logic             sensed
);
  localparam logic [WIDTH-1:0] SET_LVL = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] CLR_LVL = WIDTH'(THRESH - HYST);
  localparam sensor_state_e RESET_STATE = (INIT_LEVEL >= THRESH) ? SENSOR_ON : SENSOR_OFF;

  sensor_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SENSOR_OFF: if (level >= SET_LVL) state_d = SENSOR_ON;
      SENSOR_ON:  if (level < CLR_LVL)  state_d = SENSOR_OFF;
      default:    state_d = SENSOR_OFF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= RESET_STATE;
    else          state_q <= state_d;
  end

  assign sensed = (state_q == SENSOR_ON);
endmodule

// File: rtl/water_tank_model.sv
// rtl/water_tank_model.sv - tank plant: integrates valve commands into a level once per tick
module water_tank_model
  import irrigation_pkg::*;
#(
  parameter int LEVEL_WIDTH   = 8,
  parameter int TICK_DIV      = 1000,
  parameter int FILL_RATE     = 4,
  parameter int SPLINKER_RATE = 3,
  parameter int DRIPPER_RATE  = 1,
  parameter int LOW_THRESH    = 32,
  parameter int MID_THRESH    = 128,
  parameter int HIGH_THRESH   = 224,
  parameter int HYST          = 4,
  parameter int INIT_LEVEL    = 0
) (
  input logic                clock,
  input logic                reset_n,
  water_tank_model_if.slave  tank
);
  localparam int CNT_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W     = LEVEL_WIDTH + 2;
  localparam int MAX_LEVEL = (1 << LEVEL_WIDTH) - 1;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_LEVEL);

  if (!(LOW_THRESH < MID_THRESH && MID_THRESH < HIGH_THRESH && HIGH_THRESH <= MAX_LEVEL
        && TICK_DIV >= 2 && HYST < LOW_THRESH)) begin : g_bad_params
    $error("water_tank_model: illegal threshold/tick parameters");
  end

  logic [CNT_W-1:0]        tick_q, tick_d;
  logic [LEVEL_WIDTH-1:0]  level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic                    dry_run_q, dry_run_d;
  logic                    step_en;
  logic signed [SUM_W-1:0] add_s, sub_s, sum_s;
  logic                    low_s, mid_s, high_s;

  assign step_en = (tick_q == CNT_W'(TICK_DIV - 1));

  // Extra two bits hold both the carry past max and the sign below zero.
  always_comb begin
    add_s = tank.water_supply_valvule ? SUM_W'(FILL_RATE) : '0;
    sub_s = (tank.splinker_bomb ? SUM_W'(SPLINKER_RATE) : '0)
          + (tank.dripper_valvule ? SUM_W'(DRIPPER_RATE) : '0);
    sum_s = $signed({2'b00, level_q}) + add_s - sub_s;

    tick_d     = step_en ? '0 : tick_q + CNT_W'(1);
    level_d    = level_q;
    overflow_d = tank.clear_flags ? 1'b0 : overflow_q;
    dry_run_d  = tank.clear_flags ? 1'b0 : dry_run_q;

    if (step_en) begin
      if (sum_s > MAX_S) begin
        level_d = '1;
        if (add_s > sub_s) overflow_d = 1'b1;
      end else if (sum_s < 0) begin
        level_d = '0;
        if (sub_s > add_s) dry_run_d = 1'b1;
      end else begin
        level_d = sum_s[LEVEL_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick_q     <= '0;
      level_q    <= LEVEL_WIDTH'(INIT_LEVEL);
      overflow_q <= 1'b0;
      dry_run_q  <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      dry_run_q  <= dry_run_d;
    end
  end

  level_sensor #(.WIDTH(LEVEL_WIDTH), .THRESH(LOW_THRESH), .HYST(HYST), .INIT_LEVEL(INIT_LEVEL))
    u_low (.clock(clock), .reset_n(reset_n), .level(level_q), .sensed(low_s));
  level_sensor #(.WIDTH(LEVEL_WIDTH), .THRESH(MID_THRESH), .HYST(HYST), .INIT_LEVEL(INIT_LEVEL))
    u_mid (.clock(clock), .reset_n(reset_n), .level(level_q), .sensed(mid_s));
  level_sensor #(.WIDTH(LEVEL_WIDTH), .THRESH(HIGH_THRESH), .HYST(HYST), .INIT_LEVEL(INIT_LEVEL))
    u_high (.clock(clock), .reset_n(reset_n), .level(level_q), .sensed(high_s));

  // Faults mask only the outputs so releasing them restores the true reading at once.
  always_comb begin
    tank.low_water_level  = low_s;
    tank.mid_water_level  = mid_s;
    tank.high_water_level = high_s;
    case (tank.fault_inject)
      FAULT_NONE:      ;
      FAULT_MID_LOW:   tank.mid_water_level  = 1'b0;
      FAULT_LOW_LOW:   tank.low_water_level  = 1'b0;
      FAULT_HIGH_HIGH: tank.high_water_level = 1'b1;
      default:         ;
    endcase
  end

  assign tank.level    = level_q;
  assign tank.overflow = overflow_q;
  assign tank.dry_run  = dry_run_q;
endmodule

// File: tb/tb_water_tank_model.sv
// tb/tb_water_tank_model.sv - scoreboard bench for water_tank_model against an integer tank model
module tb_water_tank_model;
  localparam int TD   = 4;
  localparam int HYST = 4;
  localparam int MAXL = 255;

  typedef struct packed {
    logic [7:0] level;
    logic       low;
    logic       mid;
    logic       high;
    logic       ovf;
    logic       dry;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;

  water_tank_model_if #(.LEVEL_WIDTH(8)) tank_if ();

  water_tank_model #(.LEVEL_WIDTH(8), .TICK_DIV(TD)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .tank    (tank_if)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_level, m_cnt;
  bit m_sens[3];
  bit m_ovf, m_dry, m_valid;
  int thr[3] = '{32, 128, 224};

  function automatic obs_t model_obs(input logic [1:0] f);
    obs_t o;
    o.level = 8'(m_level);
    o.low   = m_sens[0] && (f != 2'b10);
    o.mid   = m_sens[1] && (f != 2'b01);
    o.high  = m_sens[2] || (f == 2'b11);
    o.ovf   = m_ovf;
    o.dry   = m_dry;
    return o;
  endfunction

  task automatic model_step(input bit rn, input bit sup, input bit spl, input bit drp, input bit clr);
    int add, sub, nxt;
    if (!rn) begin
      m_level = 0;
      m_cnt   = 0;
      m_ovf   = 0;
      m_dry   = 0;
      for (int i = 0; i < 3; i++) m_sens[i] = 0;
      m_valid = 1;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (!m_sens[i] && m_level >= thr[i]) m_sens[i] = 1;
      else if (m_sens[i] && m_level < thr[i] - HYST) m_sens[i] = 0;
    end
    if (clr) begin
      m_ovf = 0;
      m_dry = 0;
    end
    if (m_cnt == TD - 1) begin
      add = sup ? 4 : 0;
      sub = (spl ? 3 : 0) + (drp ? 1 : 0);
      nxt = m_level + add - sub;
      if (nxt > MAXL) begin
        m_level = MAXL;
        if (add > sub) m_ovf = 1;
      end else if (nxt < 0) begin
        m_level = 0;
        if (sub > add) m_dry = 1;
      end else begin
        m_level = nxt;
      end
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic cyc(input bit rn, input bit sup, input bit spl, input bit drp,
                     input logic [1:0] f, input bit clr);
    reset_n                      = rn;
    tank_if.water_supply_valvule = sup;
    tank_if.splinker_bomb        = spl;
    tank_if.dripper_valvule      = drp;
    tank_if.fault_inject         = f;
    tank_if.clear_flags          = clr;
    if (m_valid) exp_q.push_back(model_obs(f));
    @(posedge clk);
    #1;
    model_step(rn, sup, spl, drp, clr);
  endtask

  task automatic run(input int n, input bit sup, input bit spl, input bit drp, input bit clr);
    for (int i = 0; i < n * TD; i++) cyc(1'b1, sup, spl, drp, 2'b00, clr);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {tank_if.level, tank_if.low_water_level, tank_if.mid_water_level,
             tank_if.high_water_level, tank_if.overflow, tank_if.dry_run};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL obs t=%0t got level=%0d lmh=%b%b%b ovf=%b dry=%b want level=%0d lmh=%b%b%b ovf=%b dry=%b",
                   $time, a.level, a.low, a.mid, a.high, a.ovf, a.dry,
                   e.level, e.low, e.mid, e.high, e.ovf, e.dry);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    m_valid = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    run(8, 1, 0, 0, 0);
    run(25, 1, 0, 0, 0);
    run(2, 0, 0, 1, 0);
    run(3, 0, 1, 0, 0);

    run(40, 1, 0, 0, 0);
    run(1, 1, 0, 0, 1);
    run(1, 0, 0, 0, 1);

    run(70, 0, 1, 1, 0);
    run(2, 1, 1, 1, 0);

    run(64, 1, 0, 0, 0);
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'(f), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    guard = 0;
    while (m_cnt != TD - 1 && guard < 2 * TD) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
      guard++;
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    run(3, 1, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      bit fill_bias;
      fill_bias = ((i / 64) % 2) == 0;
      cyc($urandom_range(199) != 0,
          fill_bias ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0),
          1'($urandom_range(1)), 1'($urandom_range(1)),
          ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00,
          $urandom_range(15) == 0);
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/water_tank_model.md
Name: water_tank_model

Overview:
- Closed-loop plant model of the irrigation tank: the responder end of the valve/sensor interface.
- The controller drives water_supply_valvule, splinker_bomb and dripper_valvule. This block integrates those commands into a tank level and returns the low/mid/high level sensor signals the controller consumes.
- Used on-board and in benches in place of physical sensors. Supports fault injection to exercise the conflicting-values path.

Parameters:
- LEVEL_WIDTH, 8, tank level register width.
- TICK_DIV, 1000, clock cycles per simulation step (>=2).
- FILL_RATE, 4, level units added per step while the supply valve is open.
- SPLINKER_RATE, 3, units removed per step while the sprinkler pump is on.
- DRIPPER_RATE, 1, units removed per step while the dripper is on.
- LOW_THRESH, 32, low sensor set threshold.
- MID_THRESH, 128, mid sensor set threshold.
- HIGH_THRESH, 224, high sensor set threshold.
- HYST, 4, sensor clear hysteresis in level units (< LOW_THRESH).
- INIT_LEVEL, 0, level loaded at reset.

Ports:
- clock, in, 1, system clock.
- reset_n, in, 1, synchronous active-low reset.
- water_supply_valvule, in, 1, supply valve open.
- splinker_bomb, in, 1, sprinkler pump on.
- dripper_valvule, in, 1, dripper valve open.
- fault_inject, in, 2, sensor fault mode: 00 none, 01 mid stuck-0, 10 low stuck-0, 11 high stuck-1.
- clear_flags, in, 1, clears the sticky flags.
- low_water_level, out, 1, water at or above the low sensor.
- mid_water_level, out, 1, water at or above the mid sensor.
- high_water_level, out, 1, water at or above the high sensor.
- level, out, LEVEL_WIDTH, current tank level.
- overflow, out, 1, sticky: a fill was saturated at max.
- dry_run, out, 1, sticky: a drain was saturated at 0.

Behaviour:
- Clock and reset: one clock `clock`; reset `reset_n` is synchronous, active-low, sampled on the rising edge of clock.
- Reset values:
  - level = INIT_LEVEL, tick counter = 0.
  - Sensors take their set-threshold compare against INIT_LEVEL; all 0 for the default.
  - overflow = 0, dry_run = 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - step_en is asserted in the cycle the counter equals TICK_DIV-1.
  - Commands are sampled only in that cycle. Toggling them between steps has no effect.
- Level update on step_en:
  - add = water_supply_valvule ? FILL_RATE : 0.
  - sub = (splinker_bomb ? SPLINKER_RATE : 0) + (dripper_valvule ? DRIPPER_RATE : 0).
  - Computed at LEVEL_WIDTH+2 bits: next = level + add - sub, saturated to 0..2^LEVEL_WIDTH-1.
  - Simultaneous fill and drain use the net value.
  - If add > sub and the unsaturated result exceeds max, set overflow.
  - If sub > add and the unsaturated result is below 0, set dry_run.
  - Net zero leaves level unchanged and sets neither flag.
- Sensors:
  - Each sensor is a 2-state machine, OFF and ON, updated every cycle from the registered level.
  - OFF->ON when level >= THRESH.
  - ON->OFF when level < THRESH-HYST.
  - Otherwise it holds its state.
  - Sensor flops are one cycle behind level.
- Fault injection:
  - Applied combinationally after the sensor flops; it does not alter the sensor state.
  - Changing fault_inject takes effect the same cycle and releases the same cycle.
- Sticky flags:
  - clear_flags clears both flags.
  - If clear_flags coincides with a saturating step, the set wins.
- Reset mid-step: reset overrides everything, including a coinciding step_en.
- Parameter legality: require LOW_THRESH < MID_THRESH < HIGH_THRESH <= max. Check with an elaboration-time assertion.

Decomposition:
- Shared package irrigation_pkg:
  - fault code constants FAULT_NONE, FAULT_MID_LOW, FAULT_LOW_LOW, FAULT_HIGH_HIGH.
  - sensor state encoding SENSOR_OFF/SENSOR_ON.
- One sub-module, level_sensor (parameters THRESH, HYST, WIDTH; ports clock, reset_n, level, sensed), instantiated three times.

Test Plan (TICK_DIV=4, defaults otherwise):
1. Reset, then supply=1 for 8 steps (32 cycles) -> level 4,8,..,32. low_water_level rises 1 cycle after level reaches 32; mid and high stay 0.
2. From level 130 with mid ON, splinker=1 -> level 127 (mid holds); after the next step level 124 (still holds, 124 = 128-4); at level 121 mid clears 1 cycle later.
3. Level 254, supply=1 -> level 255, overflow=1 and stays set. Then clear_flags=1 coinciding with another saturating step -> overflow remains 1. clear_flags alone -> 0.
4. Level 2, splinker=1 and dripper=1 -> level 0, dry_run=1. Then supply=1 with splinker=1 and dripper=1 (net 0) -> level 0, no new flag.
5. Level 230 (all sensors ON), fault_inject=01 -> outputs low=1, mid=0, high=1 the same cycle. fault_inject=00 -> mid=1 the same cycle.
6. Assert reset_n=0 in the step_en cycle with supply=1 -> level = INIT_LEVEL, all flags 0, counter 0. The first step after release occurs 4 cycles later.
